vdp_sprite_line_scheduler: RTL and testbench

Sequences the sprite renderer against a pair of ping-pong sprite line buffers.
- Issues the per-line renderer restart and swaps the render and display banks on each line start.
- Routes renderer writes to the render bank and raster reads to the display bank.
- Clears each display-bank pixel to zero immediately after it is read.
- Sits between the sprite renderer, the two external line-buffer RAMs and the VDP raster/compositor.

---
 rtl/vdp_sprite_line_scheduler_pkg.sv | 23 ++
 rtl/vdp_line_clear_sweep.sv | 46 ++++
 rtl/vdp_sprite_line_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_vdp_sprite_line_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_sprite_line_scheduler_pkg.sv
// Shared types and constants for the sprite line scheduler: FSM encoding, pixel
// field offsets and default geometry.
package vdp_sprite_line_scheduler_pkg;

    typedef enum logic [1:0] {
        StClear  = 2'd0,
        StIdle   = 2'd1,
        StSwap   = 2'd2,
        StRender = 2'd3
    } state_e;

    localparam int unsigned DefAddrWidth = 10;
    localparam int unsigned DefDataWidth = 13;
    localparam int unsigned DefLineWidth = 1024;

    // Pixel word layout: {spare[2:0], priority[1:0], palette[3:0], colour[3:0]}
    localparam int unsigned PixColourLsb   = 0;
    localparam int unsigned PixPaletteLsb  = 4;
    localparam int unsigned PixPriorityLsb = 8;

    localparam logic [7:0] OverrunCountMax = 8'hFF;

endpackage

// File: rtl/vdp_line_clear_sweep.sv
// Address sweep used by the power-up clear: walks 0..LINE_WIDTH-1 once after reset,
// exposing busy and a last-address strobe.
module vdp_line_clear_sweep #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LINE_WIDTH = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  busy_o,
    output logic                  last_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LINE_WIDTH - 1);

    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign last_o = busy_q && (addr_q == LastAddr);
    assign busy_o = busy_q;
    assign addr_o = addr_q;

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        if (busy_q) begin
            if (last_o) begin
                busy_d = 1'b0;
                addr_d = '0;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= 1'b1;
            addr_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/vdp_sprite_line_scheduler.sv
// Ping-pong sprite line buffer scheduler: bank swap per line, renderer write routing,
// raster read with clear-behind. Optional counter: VDP_SPRITE_OVERRUN_COUNT_EN.
module vdp_sprite_line_scheduler
    import vdp_sprite_line_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LINE_WIDTH = DefLineWidth
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    line_start,
    output logic                    render_restart,
    input  logic                    render_done,
    input  logic                    rw_en,
    input  logic [ADDR_WIDTH-1:0]   rw_address,
    input  logic [DATA_WIDTH-1:0]   rw_data,
    input  logic                    raster_read_en,
    input  logic [ADDR_WIDTH-1:0]   raster_x,
    output logic [DATA_WIDTH-1:0]   pixel_out,
    output logic                    pixel_valid,
    output logic [1:0]              bank_write_en,
    output logic [2*ADDR_WIDTH-1:0] bank_write_address,
    output logic [2*DATA_WIDTH-1:0] bank_write_data,
    output logic [2*ADDR_WIDTH-1:0] bank_read_address,
    input  logic [2*DATA_WIDTH-1:0] bank_read_data,
    output logic                    display_bank,
    output logic                    clear_busy,
    output logic                    overrun,
    output logic [7:0]              overrun_count
);

    state_e state_q, state_d;
    logic   display_bank_q, display_bank_d;
    logic   render_restart_q, render_restart_d;
    logic   overrun_q, overrun_d;
    logic   overrun_event;
    logic   render_bank;

    logic                  sweep_busy, sweep_last;
    logic [ADDR_WIDTH-1:0] clear_addr;

    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  rd_zero_q, rd_zero_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] pixel_out_q, pixel_out_d;
    logic                  pixel_valid_q, pixel_valid_d;

    logic [1:0][DATA_WIDTH-1:0] rd_data;
    logic [1:0]                 wr_en;
    logic [1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [1:0][DATA_WIDTH-1:0] wr_data;
    logic [1:0][ADDR_WIDTH-1:0] rd_addr_out;

    vdp_line_clear_sweep #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_clear_sweep (
        .clk_i   (clk),
        .reset_i (reset),
        .busy_o  (sweep_busy),
        .last_o  (sweep_last),
        .addr_o  (clear_addr)
    );

    always_comb begin
        state_d        = state_q;
        display_bank_d = display_bank_q;
        overrun_event  = 1'b0;
        unique case (state_q)
            StClear:  if (sweep_last) state_d = StIdle;
            StIdle:   if (line_start) state_d = StSwap;
            StSwap:   state_d = StRender;
            StRender: begin
                if (line_start) begin
                    state_d       = StSwap;
                    overrun_event = !render_done;
                end else if (render_done) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StClear;
        endcase
        if (state_d == StSwap) display_bank_d = ~display_bank_q;
        overrun_d        = overrun_q | overrun_event;
        render_restart_d = (state_d != StRender);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StClear;
            display_bank_q   <= 1'b0;
            render_restart_q <= 1'b1;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            display_bank_q   <= display_bank_d;
            render_restart_q <= render_restart_d;
            overrun_q        <= overrun_d;
        end
    end

`ifdef VDP_SPRITE_OVERRUN_COUNT_EN
    logic [7:0] overrun_count_q, overrun_count_d;

    always_comb begin
        overrun_count_d = overrun_count_q;
        if (overrun_event && (overrun_count_q != OverrunCountMax)) begin
            overrun_count_d = overrun_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) overrun_count_q <= 8'd0;
        else       overrun_count_q <= overrun_count_d;
    end

    assign overrun_count = overrun_count_q;
`else
    assign overrun_count = 8'd0;
`endif

    assign rd_data = bank_read_data;

    always_comb begin
        rd_valid_d    = raster_read_en;
        rd_bank_d     = display_bank_q;
        rd_addr_d     = raster_x;
        rd_zero_d     = (state_q == StClear);
        pixel_valid_d = rd_valid_q;
        pixel_out_d   = pixel_out_q;
        if (rd_valid_q) pixel_out_d = rd_zero_q ? '0 : rd_data[rd_bank_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q    <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_zero_q     <= 1'b0;
            rd_addr_q     <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            rd_bank_q     <= rd_bank_d;
            rd_zero_q     <= rd_zero_d;
            rd_addr_q     <= rd_addr_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign render_bank = ~display_bank_q;

    always_comb begin
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_addr_out = '0;
        rd_addr_out[display_bank_q] = raster_x;
        if (state_q == StClear) begin
            wr_en      = 2'b11;
            wr_addr[0] = clear_addr;
            wr_addr[1] = clear_addr;
        end else begin
            if ((state_q == StRender) && rw_en) begin
                wr_en[render_bank]   = 1'b1;
                wr_addr[render_bank] = rw_address;
                wr_data[render_bank] = rw_data;
            end
            // Clear-behind overrides; it can only hit the render bank during SWAP.
            if (rd_valid_q) begin
                wr_en[rd_bank_q]   = 1'b1;
                wr_addr[rd_bank_q] = rd_addr_q;
                wr_data[rd_bank_q] = '0;
            end
        end
    end

    assign bank_write_en      = wr_en;
    assign bank_write_address = wr_addr;
    assign bank_write_data    = wr_data;
    assign bank_read_address  = rd_addr_out;
    assign render_restart     = render_restart_q;
    assign display_bank       = display_bank_q;
    assign clear_busy         = sweep_busy;
    assign overrun            = overrun_q;
    assign pixel_out          = pixel_out_q;
    assign pixel_valid        = pixel_valid_q;

endmodule

// File: tb/tb_vdp_sprite_line_scheduler.sv
// Scoreboard bench for vdp_sprite_line_scheduler with a two-bank sync-read RAM model.
module tb_vdp_sprite_line_scheduler;

    localparam int AW = 10;
    localparam int DW = 13;
`ifdef VDP_SPRITE_OVERRUN_COUNT_EN
    localparam logic [31:0] ExpCount = 32'd1;
`else
    localparam logic [31:0] ExpCount = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          reset, line_start, render_restart, render_done;
    logic          rw_en, raster_read_en, pixel_valid, display_bank, clear_busy, overrun;
    logic [AW-1:0] rw_address, raster_x;
    logic [DW-1:0] rw_data, pixel_out;
    logic [1:0]    bank_write_en;
    logic [2*AW-1:0] bank_write_address, bank_read_address;
    logic [2*DW-1:0] bank_write_data, bank_read_data;
    logic [7:0]    overrun_count;

    logic          pre_en, pre_bank;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem0 [1024];
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] rdq0, rdq1;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [DW-1:0] exp_q [$];

    vdp_sprite_line_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .line_start         (line_start),
        .render_restart     (render_restart),
        .render_done        (render_done),
        .rw_en              (rw_en),
        .rw_address         (rw_address),
        .rw_data            (rw_data),
        .raster_read_en     (raster_read_en),
        .raster_x           (raster_x),
        .pixel_out          (pixel_out),
        .pixel_valid        (pixel_valid),
        .bank_write_en      (bank_write_en),
        .bank_write_address (bank_write_address),
        .bank_write_data    (bank_write_data),
        .bank_read_address  (bank_read_address),
        .bank_read_data     (bank_read_data),
        .display_bank       (display_bank),
        .clear_busy         (clear_busy),
        .overrun            (overrun),
        .overrun_count      (overrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdq0 <= mem0[bank_read_address[AW-1:0]];
        rdq1 <= mem1[bank_read_address[2*AW-1:AW]];
        if (bank_write_en[0]) mem0[bank_write_address[AW-1:0]] <= bank_write_data[DW-1:0];
        if (bank_write_en[1]) mem1[bank_write_address[2*AW-1:AW]] <= bank_write_data[2*DW-1:DW];
        if (pre_en) begin
            if (pre_bank) mem1[pre_addr] <= pre_data;
            else          mem0[pre_addr] <= pre_data;
        end
    end
    assign bank_read_data = {rdq1, rdq0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented pixel is matched against the oldest expected one.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (pixel_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("pix_spurious", 32'(pixel_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 32'(pixel_out), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int sweep_err;
        reset = 1'b1; line_start = 1'b0; render_done = 1'b0; rw_en = 1'b0;
        rw_address = '0; rw_data = '0; raster_read_en = 1'b0; raster_x = '0;
        pre_en = 1'b0; pre_bank = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset values; preload a stale pixel the clear sweep has not reached yet.
        tick();
        pre_en = 1'b1; pre_bank = 1'b0; pre_addr = 10'h300; pre_data = 13'h1555;
        @(negedge clk);
        check("rst_clear_busy", 32'(clear_busy), 32'd1);
        check("rst_restart", 32'(render_restart), 32'd1);
        check("rst_display", 32'(display_bank), 32'd0);
        check("rst_pix_valid", 32'(pixel_valid), 32'd0);
        check("rst_pix_out", 32'(pixel_out), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ovr_count", 32'(overrun_count), 32'd0);
        tick();
        pre_en = 1'b0; reset = 1'b0;

        // Clear sweep: 1024 cycles, both banks, addresses 0..1023, with a read at k=10.
        sweep_err = 0;
        for (int k = 0; k < 1024; k++) begin
            raster_read_en = (k == 10);
            raster_x = 10'h300;
            if (k == 10) exp_q.push_back(13'h0000);
            @(negedge clk);
            if (clear_busy !== 1'b1 || bank_write_en !== 2'b11 ||
                bank_write_address !== {AW'(k), AW'(k)} || bank_write_data !== '0)
                sweep_err++;
            tick();
        end
        raster_read_en = 1'b0;
        check("clear_sweep", 32'(sweep_err), 32'd0);
        @(negedge clk);
        check("idle_clear_busy", 32'(clear_busy), 32'd0);
        check("idle_restart", 32'(render_restart), 32'd1);
        check("idle_no_write", 32'(bank_write_en), 32'd0);
        tick();

        // Line start from IDLE, then a renderer write into bank 0.
        line_start = 1'b1;
        @(negedge clk);
        check("ls_display_before", 32'(display_bank), 32'd0);
        tick();
        line_start = 1'b0;
        @(negedge clk);
        check("swap_display", 32'(display_bank), 32'd1);
        check("swap_restart", 32'(render_restart), 32'd1);
        tick();
        rw_en = 1'b1; rw_address = 10'h005; rw_data = 13'h1ABC;
        @(negedge clk);
        check("render_restart_low", 32'(render_restart), 32'd0);
        check("rw_en", 32'(bank_write_en), 32'd1);
        check("rw_addr0", 32'(bank_write_address[AW-1:0]), 32'h005);
        check("rw_data0", 32'(bank_write_data[DW-1:0]), 32'h1ABC);
        tick();
        rw_en = 1'b0;

        // Raster read from bank 1 with clear-behind, then pipelined re-reads.
        pre_en = 1'b1; pre_bank = 1'b1; pre_addr = 10'h020; pre_data = 13'h0123;
        tick();
        pre_addr = 10'h021; pre_data = 13'h0456;
        tick();
        pre_en = 1'b0;
        raster_read_en = 1'b1; raster_x = 10'h020;
        exp_q.push_back(13'h0123);
        @(negedge clk);
        check("rd_addr_routing", 32'(bank_read_address), 32'({10'h020, 10'h000}));
        tick();
        raster_read_en = 1'b0;
        @(negedge clk);
        check("cb_en", 32'(bank_write_en), 32'd2);
        check("cb_addr1", 32'(bank_write_address[2*AW-1:AW]), 32'h020);
        check("cb_data1", 32'(bank_write_data[2*DW-1:DW]), 32'd0);
        tick();
        raster_read_en = 1'b1; raster_x = 10'h020;
        exp_q.push_back(13'h0000);
        @(negedge clk);
        check("rd_latency", 32'(pixel_valid), 32'd1);
        tick();
        raster_x = 10'h021;
        exp_q.push_back(13'h0456);
        tick();
        raster_read_en = 1'b0;
        tick();

        // line_start together with render_done: no overrun.
        line_start = 1'b1; render_done = 1'b1;
        tick();
        line_start = 1'b0; render_done = 1'b0;
        @(negedge clk);
        check("both_restart", 32'(render_restart), 32'd1);
        check("both_display", 32'(display_bank), 32'd0);
        check("both_overrun", 32'(overrun), 32'd0);
        tick();
        @(negedge clk);
        check("both_render", 32'(render_restart), 32'd0);
        tick();

        // Read coinciding with line_start: clear-behind lands in SWAP, renderer write dropped.
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        pre_en = 1'b1; pre_bank = 1'b0; pre_addr = 10'h040; pre_data = 13'h0777;
        tick();
        pre_en = 1'b0;
        line_start = 1'b1; raster_read_en = 1'b1; raster_x = 10'h040;
        exp_q.push_back(13'h0777);
        tick();
        line_start = 1'b0; raster_read_en = 1'b0;
        rw_en = 1'b1; rw_address = 10'h041; rw_data = 13'h1FFF;
        @(negedge clk);
        check("swap_cb_en", 32'(bank_write_en), 32'd1);
        check("swap_cb_addr0", 32'(bank_write_address[AW-1:0]), 32'h040);
        check("swap_cb_data0", 32'(bank_write_data[DW-1:0]), 32'd0);
        check("swap_cb_display", 32'(display_bank), 32'd1);
        tick();
        rw_en = 1'b0;
        tick();

        // Overrun: two line_starts 100 cycles apart without render_done.
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        @(negedge clk);
        check("ovr1_restart", 32'(render_restart), 32'd1);
        check("ovr1_display", 32'(display_bank), 32'd0);
        tick();
        @(negedge clk);
        check("ovr1_render", 32'(render_restart), 32'd0);
        for (int i = 0; i < 98; i++) tick();
        line_start = 1'b1;
        @(negedge clk);
        check("ovr_before", 32'(overrun), 32'd0);
        tick();
        line_start = 1'b0;
        @(negedge clk);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_count", 32'(overrun_count), ExpCount);
        check("ovr2_restart", 32'(render_restart), 32'd1);
        check("ovr2_display", 32'(display_bank), 32'd1);
        tick();
        @(negedge clk);
        check("ovr2_render", 32'(render_restart), 32'd0);
        tick();

        // Reset with a read in flight: the read must vanish and the sweep restart at 0.
        raster_read_en = 1'b1; raster_x = 10'h010;
        tick();
        raster_read_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(clear_busy), 32'd1);
        check("mid_rst_pix_valid", 32'(pixel_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_display", 32'(display_bank), 32'd0);
        check("mid_rst_wr", 32'({bank_write_en, bank_write_address}), 32'({2'b11, 20'd0}));
        tick();
        @(negedge clk);
        check("mid_rst_addr1", 32'(bank_write_address), 32'({10'd1, 10'd1}));
        for (int i = 0; i < 4; i++) tick();
        check("pix_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
